// File: rtl/bsg_parity_check_stream.sv
// Receive-side parity checker for a valid/ready input stream.
// Each accepted word is tagged with a parity-mismatch flag and buffered in a
// two-entry FIFO that feeds a valid/yumi output. A saturating error counter
// and a sticky error flag summarise all accepted errored words.
module bsg_parity_check_stream #(
    parameter int width_p           = 128,
    parameter bit odd_parity_p      = 1'b0,
    parameter int err_count_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         parity_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic                         err_o,
    input  logic                         yumi_i,
    input  logic                         clear_i,
    output logic [err_count_width_p-1:0] err_count_o,
    output logic                         sticky_err_o
);

    localparam logic [err_count_width_p-1:0] err_max_lp  = {err_count_width_p{1'b1}};
    localparam logic [err_count_width_p-1:0] err_zero_lp = {err_count_width_p{1'b0}};
    localparam logic [err_count_width_p-1:0] err_one_lp  = err_count_width_p'(1'b1);

    // 1 when the received parity bit disagrees with the data word.
    function automatic logic parity_mismatch(
        input logic [width_p-1:0] data,
        input logic               parity,
        input logic               odd
    );
        return (^data) ^ parity ^ odd;
    endfunction

    // Queue storage: slot0 is always the head, slot1 the second entry.
    logic [width_p-1:0]           slot0_data_q, slot0_data_d;
    logic                         slot0_err_q,  slot0_err_d;
    logic [width_p-1:0]           slot1_data_q, slot1_data_d;
    logic                         slot1_err_q,  slot1_err_d;
    logic [1:0]                   occ_q,        occ_d;
    logic                         ready_q,      ready_d;
    logic [err_count_width_p-1:0] err_count_q,  err_count_d;
    logic                         sticky_q,     sticky_d;

    logic enq_s;
    logic deq_s;
    logic mismatch_s;

    // ready_q already reflects "not full"; reset forces it low while asserted
    // so nothing is accepted during reset.
    assign ready_o    = ready_q & ~reset_i;
    assign v_o        = (occ_q != 2'd0);
    assign data_o     = slot0_data_q;
    assign err_o      = slot0_err_q;
    assign err_count_o  = err_count_q;
    assign sticky_err_o = sticky_q;

    assign enq_s      = v_i & ready_o;
    assign deq_s      = yumi_i & v_o;
    assign mismatch_s = parity_mismatch(data_i, parity_i, odd_parity_p);

    // Queue next state: push at the tail, pop shifts slot1 into the head.
    always_comb begin
        slot0_data_d = slot0_data_q;
        slot0_err_d  = slot0_err_q;
        slot1_data_d = slot1_data_q;
        slot1_err_d  = slot1_err_q;
        occ_d        = occ_q;
        case ({enq_s, deq_s})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    slot0_data_d = data_i;
                    slot0_err_d  = mismatch_s;
                end else begin
                    slot1_data_d = data_i;
                    slot1_err_d  = mismatch_s;
                end
            end
            2'b01: begin
                occ_d        = occ_q - 2'd1;
                slot0_data_d = slot1_data_q;
                slot0_err_d  = slot1_err_q;
            end
            2'b11: begin
                // Enqueue needs occ<2 and dequeue needs occ>=1, so occ is 1:
                // the new word replaces the departing head directly.
                slot0_data_d = data_i;
                slot0_err_d  = mismatch_s;
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        ready_d = (occ_d != 2'd2);
    end

    // Error status next state: a new error on accept wins over clear.
    always_comb begin
        err_count_d = err_count_q;
        sticky_d    = sticky_q;
        if (enq_s && mismatch_s) begin
            sticky_d = 1'b1;
            if (clear_i) begin
                err_count_d = err_one_lp;
            end else if (err_count_q != err_max_lp) begin
                err_count_d = err_count_q + err_one_lp;
            end else begin
                err_count_d = err_count_q;
            end
        end else if (clear_i) begin
            err_count_d = err_zero_lp;
            sticky_d    = 1'b0;
        end else begin
            err_count_d = err_count_q;
            sticky_d    = sticky_q;
        end
    end

    // State registers with synchronous reset; reset discards queued words.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot0_data_q <= {width_p{1'b0}};
            slot0_err_q  <= 1'b0;
            slot1_data_q <= {width_p{1'b0}};
            slot1_err_q  <= 1'b0;
            occ_q        <= 2'd0;
            ready_q      <= 1'b1;
            err_count_q  <= err_zero_lp;
            sticky_q     <= 1'b0;
        end else begin
            slot0_data_q <= slot0_data_d;
            slot0_err_q  <= slot0_err_d;
            slot1_data_q <= slot1_data_d;
            slot1_err_q  <= slot1_err_d;
            occ_q        <= occ_d;
            ready_q      <= ready_d;
            err_count_q  <= err_count_d;
            sticky_q     <= sticky_d;
        end
    end

endmodule

// File: doc/bsg_parity_check_stream.md
Name: bsg_parity_check_stream

Overview:
- Receive-side parity checker for a data stream protected by a single XOR-reduction parity bit, computed by the sending side over the full data word.
- Accepts a data word plus its parity bit on a valid/ready input. Buffers it in a 2-entry queue and presents it downstream with a per-word error flag on a valid/yumi output.
- Keeps a saturating error counter and a sticky error flag for status/CSR readout.

Parameters:
- width_p, 128, data word width in bits (>=1).
- odd_parity_p, 0; 0 = even parity (parity_i == ^data_i), 1 = odd parity (parity_i == ~^data_i).
- err_count_width_p, 16, width of the saturating error counter (>=1).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  input word valid.
- data_i  input  width_p  input data word.
- parity_i  input  1  parity bit accompanying data_i.
- ready_o  output  1  input may be accepted; registered, not combinationally dependent on v_i or yumi_i.
- v_o  output  1  output word valid.
- data_o  output  width_p  head-of-queue data word.
- err_o  output  1  head word failed parity; qualified by v_o.
- yumi_i  input  1  consumer takes head word this cycle; legal only when v_o=1.
- clear_i  input  1  zeroes err_count_o and sticky_err_o.
- err_count_o  output  err_count_width_p  saturating count of accepted words with bad parity.
- sticky_err_o  output  1  set on first accepted bad word; held until clear_i or reset.

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-high (reset_i); it takes effect at the clock edge where reset_i=1.
- After reset:
  - queue empty; v_o=0.
  - err_count_o=0, sticky_err_o=0.
  - data_o and err_o are don't-care while v_o=0.
  - ready_o=0 during any cycle with reset_i=1 and 1 in the first cycle after reset deasserts.
- Accept: accept occurs when v_i & ready_o.
  - Mismatch = (^data_i) ^ parity_i ^ odd_parity_p. 1 means error.
  - Parity is computed combinationally on the input side, in the accepting cycle.
  - {data_i, mismatch} is written to the queue tail.
- Queue:
  - 2 entries, FIFO order; occupancy 0..2.
  - ready_o = (occupancy != 2), registered from next-state occupancy.
  - Sustains 1 word/cycle with yumi_i held high.
- Latency: a word accepted in cycle N appears with v_o=1 in cycle N+1. There is no input-to-output combinational path.
- Dequeue: yumi_i=1 with v_o=1 pops the head. The next entry, if any, is presented in the following cycle.
- Simultaneous enqueue and dequeue:
  - occupancy unchanged.
  - at occupancy 2, ready_o is already 0, so no enqueue is possible.
- yumi_i asserted with v_o=0 is illegal. The bench asserts on it; RTL behaviour is undefined.
- Error counter:
  - increments by 1 on each accepted word with mismatch=1.
  - holds at 2^err_count_width_p-1 (no wrap).
  - Counting happens on accept, not on dequeue.
- Sticky flag: set on any accepted mismatch word.
- clear_i and an error accept in the same cycle: the result is err_count_o=1 and sticky_err_o=1 (the new error survives the clear).
- clear_i does not affect queue contents, v_o or ready_o.
- Reset mid-operation: queued words are discarded without output, and counters are zeroed.
- The datapath carries data unmodified; errored words are still delivered, flagged with err_o=1.

Test Plan:
- Reset, then even parity with data_i=128'h0 and parity_i=0 -> v_o=1 next cycle, data_o=0, err_o=0, err_count_o=0.
- Even parity with data_i=128'h1 and parity_i=0 -> err_o=1, err_count_o=1, sticky_err_o=1. Then data_i=128'h3, parity_i=0 -> err_o=0, count stays 1.
- Backpressure: yumi_i=0 with 3 words offered back-to-back -> ready_o=0 after the 2nd accept, 3rd word held. Then yumi_i=1 -> words emerge in order; 3rd accepted the cycle after the first pop.
- Streaming with yumi_i=1 constantly, 100 random words with ~10% corrupted parity -> one output per cycle after 1-cycle latency; err_count_o equals the injected error count; err_o matches per word.
- Saturation with err_count_width_p=2 and 5 bad words -> err_count_o=3 and holds. Then clear_i together with a bad accept -> err_count_o=1, sticky_err_o=1.
- odd_parity_p=1 with data_i=128'h0 and parity_i=1 -> err_o=0. Then reset_i pulsed with 2 words queued -> v_o=0, err_count_o=0, ready_o=1 in the first cycle after reset.
